// File: rtl/filter_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : filter_loader_if
//  Description : Handshake / bus bundle between the filter loader, the filter
//                memory and the filter buffer.
//                master : loader side (drives memory strobe/address, buffer
//                         data/enable and status)
//                slave  : environment side (drives start, filter_idx and
//                         memory read data)
//  Signals     : start, filter_idx, mem_rd, mem_addr, mem_data,
//                buf_data, buf_en, busy, done
//  Revision    : 1.0  initial release
// ============================================================================
interface filter_loader_if #(
    parameter int FILT_BYTES = 16,
    parameter int NUM_FILT   = 4,
    parameter int ADDR_W     = 8
);
    localparam int FIDX_W = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;

    logic                  start;
    logic [FIDX_W-1:0]     filter_idx;
    logic                  mem_rd;
    logic [ADDR_W-1:0]     mem_addr;
    logic [31:0]           mem_data;
    logic [31:0]           buf_data;
    logic [FILT_BYTES-1:0] buf_en;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, filter_idx, mem_data,
        output mem_rd, mem_addr, buf_data, buf_en, busy, done
    );

    modport slave (
        output start, filter_idx, mem_data,
        input  mem_rd, mem_addr, buf_data, buf_en, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/filter_loader.sv
`default_nettype none
// ============================================================================
//  Module      : filter_loader
//  Description : Fetches one filter (FILT_BYTES bytes, one 32-bit word per
//                read) from filter memory and writes it into the filter
//                buffer four bytes at a time with a one-hot byte enable.
//                Pulses done once the last word has been written.
//  Ports       : clk    - clock, all state on rising edge
//                rst_n  - synchronous reset, active-low
//                bus    - filter_loader_if.master (start/filter_idx in,
//                         mem_rd/mem_addr out, mem_data in,
//                         buf_data/buf_en/busy/done out)
//  Revision    : 1.0  initial release
// ============================================================================
module filter_loader #(
    parameter int FILT_BYTES = 16,
    parameter int NUM_FILT   = 4,
    parameter int ADDR_W     = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    filter_loader_if.master       bus
);
    localparam int WORDS = FILT_BYTES / 4;
    localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_CAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;   // last issued address, held outside REQ

    logic [ADDR_W-1:0]     w_base;
    logic [ADDR_W-1:0]     w_addr;
    logic [FILT_BYTES-1:0] w_en;

    // Out-of-range indices simply wrap: the product is truncated to ADDR_W.
    assign w_base = ADDR_W'(int'(bus.filter_idx) * WORDS);
    assign w_addr = base_q + ADDR_W'(k_q);

    // Word k lands at enable bit FILT_BYTES-1-4k (the buffer maps that bit
    // to bytes 4k..4k+3).
    always_comb begin
        w_en = '0;
        for (int i = 0; i < FILT_BYTES; i++) begin
            if (i == FILT_BYTES - 1 - 4 * int'(k_q)) begin
                w_en[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            base_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        base_d       = base_q;
        addr_d       = addr_q;
        bus.mem_rd   = 1'b0;
        bus.mem_addr = addr_q;
        bus.buf_data = '0;
        bus.buf_en   = '0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    base_d  = w_base;
                    k_d     = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = w_addr;
                bus.busy     = 1'b1;
                addr_d       = w_addr;
                state_d      = S_CAP;
            end
            S_CAP: begin
                // Memory returns data one cycle after the strobe, so it is
                // forwarded straight through in this cycle.
                bus.buf_data = bus.mem_data;
                bus.buf_en   = w_en;
                bus.busy     = 1'b1;
                if (k_q == KW'(WORDS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_filter_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_filter_loader
//  Description : Self-checking bench for filter_loader. Expected memory
//                addresses, buffer enables and buffer data are queued when a
//                load is launched and popped as the loader produces them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_filter_loader;
    localparam int FILT_BYTES = 16;
    localparam int NUM_FILT   = 4;
    localparam int ADDR_W     = 8;

    logic clk;
    logic rst_n;

    filter_loader_if #(.FILT_BYTES(FILT_BYTES), .NUM_FILT(NUM_FILT), .ADDR_W(ADDR_W)) bus ();

    filter_loader #(.FILT_BYTES(FILT_BYTES), .NUM_FILT(NUM_FILT), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    bit mon_en = 1'b0;
    bit prev_rd = 1'b0;

    logic [31:0] mem [256];
    logic [7:0]  fbuf [FILT_BYTES];

    int          q_addr [$];
    logic [15:0] q_en   [$];
    logic [31:0] q_data [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Filter memory: registered read, data valid the cycle after mem_rd.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
    end

    // Monitor: one-hot check, scoreboard pops, filter-buffer model.
    logic [15:0] m_en;
    logic [31:0] m_data;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("onehot0", 64'($onehot0(bus.buf_en)), 64'd1);
            if (prev_rd) begin
                chk("cap_expected", 64'(q_en.size() != 0), 64'd1);
                if (q_en.size() != 0) begin
                    m_en   = q_en.pop_front();
                    m_data = q_data.pop_front();
                    chk("buf_en", 64'(bus.buf_en), 64'(m_en));
                    chk("buf_data", 64'(bus.buf_data), 64'(m_data));
                end
            end else begin
                chk("idle_buf_en", 64'(bus.buf_en), 64'd0);
                chk("idle_buf_data", 64'(bus.buf_data), 64'd0);
            end
            if (bus.mem_rd) begin
                chk("rd_expected", 64'(q_addr.size() != 0), 64'd1);
                if (q_addr.size() != 0) chk("mem_addr", 64'(bus.mem_addr), 64'(q_addr.pop_front()));
            end
            for (int b = 0; b < FILT_BYTES; b++) begin
                if (bus.buf_en[b]) begin
                    for (int j = 0; j < 4; j++) fbuf[4 * ((FILT_BYTES - 1 - b) / 4) + j] = bus.buf_data[8*j +: 8];
                end
            end
            if (bus.done) n_done++;
            prev_rd = bus.mem_rd;
        end
    end

    task automatic push_load(input int idx);
        for (int k = 0; k < 4; k++) begin
            q_addr.push_back((idx * 4 + k) % 256);
            q_en.push_back(16'h8000 >> (4 * k));
            q_data.push_back(mem[(idx * 4 + k) % 256]);
        end
    endtask

    // Waits for done after the sampling edge; returns cycle index (0 = timeout).
    task automatic wait_done(input bit toggle, output int got);
        got = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) chk("busy_after_start", 64'(bus.busy), 64'd1);
            if (toggle) bus.filter_idx = ~bus.filter_idx;
            if (bus.done) begin
                got = c;
                chk("busy_at_done", 64'(bus.busy), 64'd0);
                break;
            end
        end
    endtask

    // Called aligned at posedge+1.
    task automatic run_load(input int idx, input bit toggle, input string tag);
        int got;
        push_load(idx);
        bus.start      = 1'b1;
        bus.filter_idx = 2'(idx);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(toggle, got);
        chk(tag, 64'(got), 64'd9);
        @(posedge clk); #1;
    endtask

    int got;
    int done_snap;

    initial begin
        for (int w = 0; w < 256; w++)
            for (int j = 0; j < 4; j++) mem[w][8*j +: 8] = 8'((4 * w + j) & 8'hFF);
        for (int i = 0; i < FILT_BYTES; i++) fbuf[i] = 8'h00;
        bus.start      = 1'b0;
        bus.filter_idx = '0;
        bus.mem_data   = '0;
        rst_n          = 1'b0;

        // 1: reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_rd", 64'(bus.mem_rd), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_buf_data", 64'(bus.buf_data), 64'd0);
        chk("rst_buf_en", 64'(bus.buf_en), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // 2: single load of filter 0, buffer byte i == i
        run_load(0, 1'b0, "done_cycle_idx0");
        for (int i = 0; i < FILT_BYTES; i++) chk($sformatf("fbuf[%0d]", i), 64'(fbuf[i]), 64'(i));
        chk("idle_busy", 64'(bus.busy), 64'd0);
        chk("mem_addr_hold", 64'(bus.mem_addr), 64'd3);

        // 3: indexed load, filter 2
        run_load(2, 1'b0, "done_cycle_idx2");
        chk("queue_empty_idx2", 64'(q_addr.size() + q_en.size()), 64'd0);

        // 4: start held high -> exactly two back-to-back loads
        done_snap = n_done;
        push_load(1);
        push_load(1);
        bus.start      = 1'b1;
        bus.filter_idx = 2'd1;
        @(posedge clk); #1;
        wait_done(1'b0, got);
        chk("held_first_done", 64'(got), 64'd9);
        @(posedge clk); #1;          // now IDLE, start still high
        @(posedge clk); #1;          // sampled: second load begins
        bus.start = 1'b0;
        wait_done(1'b0, got);
        chk("held_second_done", 64'(got), 64'd9);
        repeat (12) @(posedge clk);
        #1;
        chk("held_done_count", 64'(n_done - done_snap), 64'd2);
        chk("held_queue_empty", 64'(q_addr.size() + q_en.size()), 64'd0);

        // 5: reset during CAP of word 2 -> IDLE, no done
        done_snap = n_done;
        push_load(3);
        bus.start      = 1'b1;
        bus.filter_idx = 2'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);   // now in CAP of word 2
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q_addr.delete();
        q_en.delete();
        q_data.delete();
        chk("abort_mem_rd", 64'(bus.mem_rd), 64'd0);
        chk("abort_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("abort_buf_en", 64'(bus.buf_en), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(n_done - done_snap), 64'd0);

        // 6: filter_idx toggled every cycle during the load
        run_load(1, 1'b1, "done_cycle_toggle");
        chk("toggle_queue_empty", 64'(q_addr.size() + q_en.size()), 64'd0);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
